// File: rtl/iob_pfsm_banked.sv
// Programmable Mealy FSM with banked transition LUTs, a dwell counter per
// transition, registered outputs and write-protection of the running bank.
module iob_pfsm_banked #(
  parameter  int INPUT_W  = 2,
  parameter  int STATE_W  = 2,
  parameter  int OUTPUT_W = 4,
  parameter  int CNT_W    = 4,
  parameter  int N_BANKS  = 2,
  localparam int BANK_W   = (N_BANKS > 2) ? $clog2(N_BANKS) : 1,
  localparam int ENTRY_W  = CNT_W + STATE_W + OUTPUT_W,
  localparam int ADDR_W   = STATE_W + INPUT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                run_i,
  input  logic [INPUT_W-1:0]  input_i,
  output logic [OUTPUT_W-1:0] output_o,
  input  logic                prog_valid_i,
  output logic                prog_ready_o,
  input  logic [BANK_W-1:0]   prog_bank_i,
  input  logic [ADDR_W-1:0]   prog_addr_i,
  input  logic [ENTRY_W-1:0]  prog_data_i,
  output logic                prog_err_o,
  input  logic                swap_i,
  input  logic [BANK_W-1:0]   swap_bank_i,
  output logic [STATE_W-1:0]  state_o,
  output logic [BANK_W-1:0]   active_bank_o,
  output logic                busy_o
);

  localparam int LUT_AW    = BANK_W + ADDR_W;
  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef struct packed {
    logic [CNT_W-1:0]    hold;
    logic [STATE_W-1:0]  next_state;
    logic [OUTPUT_W-1:0] out;
  } entry_t;

  typedef enum logic {PH_EVAL, PH_HOLD} phase_t;

  logic [ENTRY_W-1:0]  lut [LUT_DEPTH];

  logic [STATE_W-1:0]  state;
  logic [OUTPUT_W-1:0] outputs;
  logic [CNT_W-1:0]    cnt;
  logic [BANK_W-1:0]   active_bank;
  logic                err;

  logic [LUT_AW-1:0]   rd_idx;
  logic [LUT_AW-1:0]   wr_idx;
  entry_t              rd_entry;
  logic                wr_accept;
  phase_t              phase;

  assign rd_idx   = {active_bank, state, input_i};
  assign wr_idx   = {prog_bank_i, prog_addr_i};
  assign rd_entry = entry_t'(lut[rd_idx]);
  assign phase    = (cnt == '0) ? PH_EVAL : PH_HOLD;

  // Acceptance is judged against the bank active before any same-cycle swap.
  assign wr_accept = prog_valid_i && !((prog_bank_i == active_bank) && run_i);

  // LUT write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (cke_i && !rst_i && wr_accept) begin
      lut[wr_idx] <= prog_data_i;
    end
  end

  // Core sequencing: swap restarts the new bank, otherwise evaluate or count down.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= '0;
      outputs     <= '0;
      cnt         <= '0;
      active_bank <= '0;
      err         <= 1'b0;
    end else if (cke_i) begin
      err <= prog_valid_i && !wr_accept;
      if (swap_i) begin
        active_bank <= swap_bank_i;
        state       <= '0;
        cnt         <= '0;
      end else if (run_i) begin
        unique case (phase)
          PH_EVAL: begin
            state   <= rd_entry.next_state;
            outputs <= rd_entry.out;
            cnt     <= rd_entry.hold;
          end
          PH_HOLD: begin
            cnt <= cnt - CNT_ONE;
          end
        endcase
      end
    end
  end

  assign output_o      = outputs;
  assign state_o       = state;
  assign active_bank_o = active_bank;
  assign busy_o        = (phase == PH_HOLD);
  assign prog_err_o    = err;
  assign prog_ready_o  = 1'b1;

endmodule

// File: tb/tb_iob_pfsm_banked.sv
// Directed vector bench for iob_pfsm_banked (default parameters).
module tb_iob_pfsm_banked;

  logic       clk = 1'b0;
  logic       rst_i, cke_i, run_i;
  logic [1:0] input_i;
  logic [3:0] output_o;
  logic       prog_valid_i, prog_ready_o, prog_err_o;
  logic       prog_bank_i;
  logic [3:0] prog_addr_i;
  logic [9:0] prog_data_i;
  logic       swap_i, swap_bank_i;
  logic [1:0] state_o;
  logic       active_bank_o, busy_o;

  int nvec = 0;
  int nerr = 0;

  iob_pfsm_banked #(
    .INPUT_W (2),
    .STATE_W (2),
    .OUTPUT_W(4),
    .CNT_W   (4),
    .N_BANKS (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cke_i        (cke_i),
    .run_i        (run_i),
    .input_i      (input_i),
    .output_o     (output_o),
    .prog_valid_i (prog_valid_i),
    .prog_ready_o (prog_ready_o),
    .prog_bank_i  (prog_bank_i),
    .prog_addr_i  (prog_addr_i),
    .prog_data_i  (prog_data_i),
    .prog_err_o   (prog_err_o),
    .swap_i       (swap_i),
    .swap_bank_i  (swap_bank_i),
    .state_o      (state_o),
    .active_bank_o(active_bank_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, cke, run;
    logic [1:0] din;
    logic       pv, pb;
    logic [3:0] pa;
    logic [9:0] pd;
    logic       sw, sb;
    logic [3:0] eo;
    logic [1:0] es;
    logic       eb, ebusy, eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] ent(input int h, input int ns, input int o);
    logic [3:0] hh;
    logic [1:0] nn;
    logic [3:0] oo;
    hh = h[3:0];
    nn = ns[1:0];
    oo = o[3:0];
    return {hh, nn, oo};
  endfunction

  task automatic addv(input logic rst, input logic cke, input logic run, input logic [1:0] din,
                      input logic pv, input logic pb, input logic [3:0] pa, input logic [9:0] pd,
                      input logic sw, input logic sb, input logic [3:0] eo, input logic [1:0] es,
                      input logic eb, input logic ebusy, input logic eerr);
    vec_t v;
    v = '{rst, cke, run, din, pv, pb, pa, pd, sw, sb, eo, es, eb, ebusy, eerr};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst_i        = v.rst;
    cke_i        = v.cke;
    run_i        = v.run;
    input_i      = v.din;
    prog_valid_i = v.pv;
    prog_bank_i  = v.pb;
    prog_addr_i  = v.pa;
    prog_data_i  = v.pd;
    swap_i       = v.sw;
    swap_bank_i  = v.sb;
  endtask

  task automatic set_run(input logic run, input logic [1:0] din);
    rst_i = 1'b0; cke_i = 1'b1; run_i = run; input_i = din;
    prog_valid_i = 1'b0; prog_bank_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
    swap_i = 1'b0; swap_bank_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eo, input logic [1:0] es,
                       input logic eb, input logic ebusy, input logic eerr);
    nvec++;
    if ({output_o, state_o, active_bank_o, busy_o, prog_err_o, prog_ready_o} !==
        {eo, es, eb, ebusy, eerr, 1'b1}) begin
      nerr++;
      $display("FAIL %s: got out=%h state=%0d bank=%0d busy=%b err=%b ready=%b, want out=%h state=%0d bank=%0d busy=%b err=%b ready=1",
               name, output_o, state_o, active_bank_o, busy_o, prog_err_o, prog_ready_o,
               eo, es, eb, ebusy, eerr);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int stable;

    set_run(1'b0, 2'd0);
    rst_i = 1'b1;

    // rst cke run in pv pb pa pd sw sb | out state bank busy err
    addv(1,1,0,0, 0,0,4'h0,10'h0, 0,0, 4'h0,0,0,0,0);
    for (int i = 0; i < 10; i++)
      addv(0,1,0,0, 0,0,4'h0,10'h0, 0,0, 4'h0,0,0,0,0);
    // program bank 0 while halted
    addv(0,1,0,0, 1,0,4'b0001,ent(0,1,'hA), 0,0, 4'h0,0,0,0,0);
    for (int a = 4; a < 8; a++)
      addv(0,1,0,0, 1,0,a[3:0],ent(0,0,'h5), 0,0, 4'h0,0,0,0,0);
    addv(0,1,0,0, 1,0,4'b0010,ent(3,2,'h3), 0,0, 4'h0,0,0,0,0);
    addv(0,1,0,0, 1,0,4'b1010,ent(0,0,'hC), 0,0, 4'h0,0,0,0,0);
    addv(0,1,0,0, 1,0,4'b0011,ent(5,3,'h9), 0,0, 4'h0,0,0,0,0);
    // toggler
    addv(0,1,1,1, 0,0,4'h0,10'h0, 0,0, 4'hA,1,0,0,0);
    addv(0,1,1,1, 0,0,4'h0,10'h0, 0,0, 4'h5,0,0,0,0);
    addv(0,1,1,1, 0,0,4'h0,10'h0, 0,0, 4'hA,1,0,0,0);
    addv(0,1,1,1, 0,0,4'h0,10'h0, 0,0, 4'h5,0,0,0,0);
    // dwell hold=3 with a run_i=0 pause in the middle
    addv(0,1,1,2, 0,0,4'h0,10'h0, 0,0, 4'h3,2,0,1,0);
    addv(0,1,1,2, 0,0,4'h0,10'h0, 0,0, 4'h3,2,0,1,0);
    addv(0,1,0,0, 0,0,4'h0,10'h0, 0,0, 4'h3,2,0,1,0);
    addv(0,1,0,0, 0,0,4'h0,10'h0, 0,0, 4'h3,2,0,1,0);
    addv(0,1,1,3, 0,0,4'h0,10'h0, 0,0, 4'h3,2,0,1,0);
    addv(0,1,1,2, 0,0,4'h0,10'h0, 0,0, 4'h3,2,0,0,0);
    addv(0,1,1,2, 0,0,4'h0,10'h0, 0,0, 4'hC,0,0,0,0);
    // write protection during a hold=5 dwell, then swap mid-dwell
    addv(0,1,1,3, 0,0,4'h0,10'h0, 0,0, 4'h9,3,0,1,0);
    addv(0,1,1,3, 1,0,4'b0001,ent(0,2,'hE), 0,0, 4'h9,3,0,1,1);
    addv(0,1,1,3, 1,1,4'b0001,ent(0,2,'hE), 0,0, 4'h9,3,0,1,0);
    addv(0,1,1,3, 1,1,4'b0011,ent(0,1,'hF), 0,0, 4'h9,3,0,1,0);
    addv(0,1,1,3, 0,0,4'h0,10'h0, 1,1, 4'h9,0,1,0,0);
    addv(0,1,1,3, 0,0,4'h0,10'h0, 0,0, 4'hF,1,1,0,0);
    // swap + write to the new bank in one cycle
    addv(0,1,0,0, 0,0,4'h0,10'h0, 1,0, 4'hF,0,0,0,0);
    addv(0,1,1,1, 1,1,4'b0001,ent(0,3,'h6), 1,1, 4'hF,0,1,0,0);
    addv(0,1,1,1, 0,0,4'h0,10'h0, 0,0, 4'h6,3,1,0,0);
    // back to bank 0: rejected write must have left entry A/s1
    addv(0,1,1,1, 0,0,4'h0,10'h0, 1,0, 4'h6,0,0,0,0);
    addv(0,1,1,1, 0,0,4'h0,10'h0, 0,0, 4'hA,1,0,0,0);
    addv(0,1,1,2, 0,0,4'h0,10'h0, 0,0, 4'h5,0,0,0,0);
    addv(0,1,1,2, 0,0,4'h0,10'h0, 0,0, 4'h3,2,0,1,0);
    // reset mid-hold with a write that must be dropped
    addv(1,1,1,2, 1,1,4'b0001,ent(0,1,'hB), 0,0, 4'h0,0,0,0,0);
    addv(0,1,0,0, 0,0,4'h0,10'h0, 1,1, 4'h0,0,1,0,0);
    addv(0,1,1,1, 0,0,4'h0,10'h0, 0,0, 4'h6,3,1,0,0);
    // clock enable low freezes state, swap and writes
    addv(0,0,1,1, 1,0,4'b0001,ent(0,2,'hD), 1,0, 4'h6,3,1,0,0);
    addv(0,1,0,0, 0,0,4'h0,10'h0, 1,0, 4'h6,0,0,0,0);
    addv(0,1,1,1, 0,0,4'h0,10'h0, 0,0, 4'hA,1,0,0,0);
    // maximum-hold entry for the hand-written sequence
    addv(0,1,0,0, 1,0,4'b0000,ent(15,0,'h7), 0,0, 4'hA,1,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check($sformatf("vec%0d", i), vecs[i].eo, vecs[i].es, vecs[i].eb, vecs[i].ebusy, vecs[i].eerr);
    end

    // hold = 2^CNT_W-1: 15 busy cycles, frozen outputs, no counter wrap
    set_run(1'b1, 2'd1);
    step();
    check("maxhold_pre", 4'h5, 2'd0, 1'b0, 1'b0, 1'b0);
    input_i = 2'd0;
    step();
    check("maxhold_eval", 4'h7, 2'd0, 1'b0, 1'b1, 1'b0);
    busy_n = 1;
    stable = 1;
    for (int i = 0; i < 40 && busy_o; i++) begin
      input_i = 2'(i);
      step();
      if (busy_o) busy_n++;
      if (output_o !== 4'h7 || state_o !== 2'd0) stable = 0;
    end
    check_int("maxhold_busy_cycles", busy_n, 15);
    check_int("maxhold_frozen", stable, 1);
    input_i = 2'd0;
    step();
    check("maxhold_reeval", 4'h7, 2'd0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/iob_pfsm_banked.md
# iob_pfsm_banked

Programmable Mealy finite-state machine with N_BANKS independent transition LUTs, a per-transition dwell counter and registered outputs. The core evaluates one active bank while software reprograms any inactive bank through a valid/ready write port, then switches banks atomically. It sits between a CSR/bus adapter (programming side) and the datapath it sequences (inputs/outputs side). It succeeds the single-bank PFSM with multi-bank atomic reprogramming, run/halt control, timed state holds and write-protection of the active bank.

## Interface
- INPUT_W, 2: width of `input_i`; LUT address low bits.
- STATE_W, 2: state register width; LUT address high bits.
- OUTPUT_W, 4: width of `output_o`.
- CNT_W, 4: dwell-counter width; also the width of the LUT entry `hold` field.
- N_BANKS, 2: number of LUT banks, power of 2, ≥2.
- Derived: BANK_W = max(1, clog2(N_BANKS)); ENTRY_W = CNT_W+STATE_W+OUTPUT_W; entry layout {hold, next_state, out}, with out in the LSBs.

Ports:
- clk_i, in, 1: the only clock.
- rst_i, in, 1: synchronous, active-high reset.
- cke_i, in, 1: clock enable. When low, all registers and LUT writes freeze.
- run_i, in, 1: evaluate the FSM when high.
- input_i, in, INPUT_W: FSM inputs.
- output_o, out, OUTPUT_W: registered FSM outputs.
- prog_valid_i, in, 1: LUT write request.
- prog_ready_o, out, 1: always 1. Writes complete in one cycle.
- prog_bank_i, in, BANK_W: target bank.
- prog_addr_i, in, STATE_W+INPUT_W: entry address {state, input}.
- prog_data_i, in, ENTRY_W: entry data.
- prog_err_o, out, 1: one-cycle pulse when a write is rejected.
- swap_i, in, 1: one-cycle pulse requesting a bank switch.
- swap_bank_i, in, BANK_W: bank to activate.
- state_o, out, STATE_W: current state.
- active_bank_o, out, BANK_W: active bank.
- busy_o, out, 1: dwell counter ≠ 0.

## Operation
- Storage is N_BANKS × 2^(STATE_W+INPUT_W) entries of ENTRY_W bits.
  - Read is combinational, addressed {active_bank, state, input_i}.
  - LUT contents are not reset. Software must program a bank before running it.
- Write acceptance:
  - A write with `prog_valid_i`=1 is accepted unless `prog_bank_i`==active_bank and `run_i`=1.
  - A rejected write leaves the LUT unchanged and pulses `prog_err_o` the next cycle.
  - Writes to the active bank with `run_i`=0 are allowed.
- Two phases:
  - EVAL: dwell counter `cnt`=0.
  - HOLD: `cnt`≠0.
- EVAL with `run_i`=1: the addressed entry `e` is applied at the clock edge:
  - state ← e.next_state
  - output_o ← e.out
  - cnt ← e.hold
- HOLD with `run_i`=1: cnt ← cnt−1. State, `output_o` and `input_i` sampling are all frozen.
- `run_i`=0: state, `cnt` and `output_o` hold. The FSM resumes exactly where it stopped.
- Swap, on `swap_i`=1:
  - active_bank ← swap_bank_i
  - state ← 0
  - cnt ← 0
  - `output_o` holds until the next EVAL.
  - The swap overrides any EVAL/HOLD update in the same cycle.
  - A swap to the already-active bank acts as a restart.
  - An out-of-range `swap_bank_i` (non-power-of-2 misuse) is not supported.
- Swap and write in the same cycle: write acceptance is checked against the pre-swap active bank. A write accepted in that cycle lands before the first evaluation of the new bank.

## Timing
- Reset values: state_o=0, active_bank_o=0, output_o=0, busy_o=0, prog_err_o=0, cnt=0.
- Output latency: `input_i` sampled at edge k (EVAL) → `output_o` and `state_o` valid after edge k.
- Dwell: an entry with hold=h occupies 1+h cycles before the next EVAL. hold=2^CNT_W−1 is the maximum, with no wrap.
- Write:
  - The accepting edge updates the entry.
  - A read of the same entry in the following cycle returns new data.
  - A same-cycle read (non-active bank only) is irrelevant.
- Swap: the edge with `swap_i`=1 is followed by EVAL of state 0 in the new bank on the next edge, if `run_i`=1.
- Reset mid-HOLD or mid-write: all registers return to reset values the same edge. Any write in that cycle is dropped.
- `cke_i`=0 overrides everything except `rst_i`.

## Test plan
1. Reset and idle.
   - Stimulus: assert `rst_i`, then hold `run_i`=0 for 10 cycles.
   - Required response: output_o=0, state_o=0, active_bank_o=0, busy_o=0 throughout.
2. Basic toggler.
   - Stimulus: program bank 0 as {s0,in=1}→{hold 0, s1, out 4'hA} and {s1,any}→{hold 0, s0, out 4'h5}; set input_i=1, run_i=1.
   - Required response: output_o alternates A,5,A,5 every cycle; state_o alternates 1,0.
3. Dwell.
   - Stimulus: program entry hold=3.
   - Required response: busy_o high for exactly 3 cycles; output_o and state_o constant for 4 cycles total; run_i=0 mid-hold freezes the count and resumes without loss.
4. Write protection.
   - Stimulus: with run_i=1, write bank 0 while bank 0 is active.
   - Required response: prog_err_o pulses once and the entry is unchanged. The same write to bank 1 succeeds with no error.
5. Atomic swap.
   - Stimulus: program bank 1 output 4'hF, pulse swap_i with swap_bank_i=1 during a hold=5 dwell.
   - Required response: cnt cleared, state_o=0, active_bank_o=1, output_o=F one cycle later.
6. Simultaneous events.
   - Stimulus: a swap to bank 1 and a write to bank 1 in the same cycle.
   - Required response: the write is accepted and the first evaluation uses the new entry.
   - Stimulus: `rst_i` during hold.
   - Required response: all outputs return to 0 on the next edge.
